// File: rtl/dac_serial_driver.sv
// rtl/dac_serial_driver.sv - paced 4-channel serial DAC driver with shared SCLK/SYNC and LDAC update
module dac_serial_driver #(
  parameter int SAMPLE_DIV = 512,
  parameter int DAC_BITS   = 24,
  parameter int SCLK_HALF  = 2
) (
  input  logic         capture_clk,
  input  logic         capture_rst_n,
  input  logic         dac_open,
  input  logic [127:0] dac_buffer,
  input  logic         dac_underrun,
  output logic         dac_request,
  output logic         dac_sclk,
  output logic         dac_sync_n,
  output logic [3:0]   dac_sdo,
  output logic         dac_ldac_n,
  output logic [15:0]  underrun_count
);

  // Shifting relies on DAC_BITS >= 2 so that the next-bit index below is valid.
  localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int BIT_W  = (DAC_BITS > 1) ? $clog2(DAC_BITS) : 1;
  localparam int PH_W   = $clog2(2 * SCLK_HALF);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DAC_BITS - 1);
  localparam logic [PH_W-1:0]   PH_RISE   = PH_W'(SCLK_HALF - 1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(2 * SCLK_HALF - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_LDAC  = 3'd5;

  logic [2:0]          state;
  logic [TICK_W-1:0]   tick;
  logic [BIT_W-1:0]    bit_cnt;
  logic [PH_W-1:0]     ph_cnt;
  logic                ldac_cnt;
  logic [DAC_BITS-1:0] top_bits [4];
  logic [DAC_BITS-1:0] shreg    [4];

  // Top DAC_BITS of each 32-bit channel word; channel 0 sits in the highest word.
  for (genvar c = 0; c < 4; c++) begin : g_ch
    assign top_bits[c] = dac_buffer[127 - 32*c -: DAC_BITS];
  end

  // The low bits of each word are not transmitted.
  if (DAC_BITS < 32) begin : g_low
    logic unused_low_bits;
    assign unused_low_bits = ^{dac_buffer[96 +: 32-DAC_BITS], dac_buffer[64 +: 32-DAC_BITS],
                               dac_buffer[32 +: 32-DAC_BITS], dac_buffer[0 +: 32-DAC_BITS]};
  end

  // Request is a decode of the registered state and tick, so it clears at once on reset.
  assign dac_request = dac_open && (state == S_WAIT) && (tick == TICK_LAST);

  // Sample-period tick: held at 0 while closed or idle, wraps at SAMPLE_DIV-1 otherwise.
  always_ff @(posedge capture_clk or negedge capture_rst_n) begin
    if (!capture_rst_n) begin
      tick <= '0;
    end else if (!dac_open || state == S_IDLE) begin
      tick <= '0;
    end else if (tick == TICK_LAST) begin
      tick <= '0;
    end else begin
      tick <= tick + 1'b1;
    end
  end

  // Saturating underrun counter, cleared while the buffer is closed.
  always_ff @(posedge capture_clk or negedge capture_rst_n) begin
    if (!capture_rst_n) begin
      underrun_count <= '0;
    end else if (!dac_open) begin
      underrun_count <= '0;
    end else if (dac_underrun && underrun_count != 16'hFFFF) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end

  // Frame sequencer: request, capture, shift, gap, LDAC; a closed buffer aborts to idle.
  always_ff @(posedge capture_clk or negedge capture_rst_n) begin
    if (!capture_rst_n) begin
      state      <= S_IDLE;
      dac_sclk   <= 1'b1;
      dac_sync_n <= 1'b1;
      dac_sdo    <= '0;
      dac_ldac_n <= 1'b1;
      bit_cnt    <= '0;
      ph_cnt     <= '0;
      ldac_cnt   <= 1'b0;
      for (int c = 0; c < 4; c++) shreg[c] <= '0;
    end else if (!dac_open) begin
      state      <= S_IDLE;
      dac_sclk   <= 1'b1;
      dac_sync_n <= 1'b1;
      dac_sdo    <= '0;
      dac_ldac_n <= 1'b1;
      bit_cnt    <= '0;
      ph_cnt     <= '0;
      ldac_cnt   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (tick == TICK_LAST) state <= S_LOAD;
        end
        S_LOAD: begin
          // Upstream latched the buffer on the request cycle, so it is stable here.
          for (int c = 0; c < 4; c++) begin
            shreg[c]   <= top_bits[c];
            dac_sdo[c] <= top_bits[c][DAC_BITS-1];
          end
          dac_sclk   <= 1'b0;
          dac_sync_n <= 1'b0;
          bit_cnt    <= '0;
          ph_cnt     <= '0;
          state      <= S_SHIFT;
        end
        S_SHIFT: begin
          if (ph_cnt == PH_RISE) dac_sclk <= 1'b1;
          if (ph_cnt == PH_LAST) begin
            ph_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              dac_sync_n <= 1'b1;
              dac_sclk   <= 1'b1;
              dac_sdo    <= '0;
              state      <= S_GAP;
            end else begin
              // New data only at the start of a low phase, so it is stable across the rising edge.
              bit_cnt  <= bit_cnt + 1'b1;
              dac_sclk <= 1'b0;
              for (int c = 0; c < 4; c++) begin
                dac_sdo[c] <= shreg[c][DAC_BITS-2];
                shreg[c]   <= {shreg[c][DAC_BITS-2:0], 1'b0};
              end
            end
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        S_GAP: begin
          dac_ldac_n <= 1'b0;
          ldac_cnt   <= 1'b0;
          state      <= S_LDAC;
        end
        S_LDAC: begin
          if (ldac_cnt) begin
            dac_ldac_n <= 1'b1;
            state      <= S_WAIT;
          end else begin
            ldac_cnt <= 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          dac_sclk   <= 1'b1;
          dac_sync_n <= 1'b1;
          dac_sdo    <= '0;
          dac_ldac_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_serial_driver.sv
// tb/tb_dac_serial_driver.sv - scoreboard bench for dac_serial_driver
module tb_dac_serial_driver;

  localparam int DIV  = 128;
  localparam int BITS = 24;
  localparam int HALF = 1;

  logic         capture_clk = 1'b0;
  logic         capture_rst_n;
  logic         dac_open;
  logic [127:0] dac_buffer;
  logic         dac_underrun;
  logic         dac_request;
  logic         dac_sclk;
  logic         dac_sync_n;
  logic [3:0]   dac_sdo;
  logic         dac_ldac_n;
  logic [15:0]  underrun_count;

  dac_serial_driver #(.SAMPLE_DIV(DIV), .DAC_BITS(BITS), .SCLK_HALF(HALF)) dut (
    .capture_clk   (capture_clk),
    .capture_rst_n (capture_rst_n),
    .dac_open      (dac_open),
    .dac_buffer    (dac_buffer),
    .dac_underrun  (dac_underrun),
    .dac_request   (dac_request),
    .dac_sclk      (dac_sclk),
    .dac_sync_n    (dac_sync_n),
    .dac_sdo       (dac_sdo),
    .dac_ldac_n    (dac_ldac_n),
    .underrun_count(underrun_count)
  );

  always #5 capture_clk = ~capture_clk;

  int cyc = 0;
  always @(posedge capture_clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  typedef struct packed {
    logic [95:0] words;   // {ch0, ch1, ch2, ch3}, 24 bits each
    int          nbits;
  } frame_t;

  frame_t exp_frames[$];
  int     exp_req[$];
  int     nbits_override[$];
  int     open_seq = 0;

  // Stimulus vectors with hand-written expected 24-bit payloads.
  logic [127:0] vecs     [3];
  logic [95:0]  exp_words[3];
  initial begin
    vecs[0]      = {32'hA5A5A53C, 32'h123456C3, 32'h800000FF, 32'h7FFFFF01};
    exp_words[0] = {24'hA5A5A5, 24'h123456, 24'h800000, 24'h7FFFFF};
    vecs[1]      = {32'hFFFFFF00, 32'h000000FF, 32'h5A5A5A0F, 32'hC3C3C3F0};
    exp_words[1] = {24'hFFFFFF, 24'h000000, 24'h5A5A5A, 24'hC3C3C3};
    vecs[2]      = {32'h000001AA, 32'h80000155, 32'hFEDCBA99, 32'h13579B66};
    exp_words[2] = {24'h000001, 24'h800001, 24'hFEDCBA, 24'h13579B};
  end

  // Upstream model: on a request, present the next vector and push its expected frame.
  frame_t up_f;
  int     vidx = 0;
  initial begin
    dac_buffer = '0;
    forever begin
      @(negedge capture_clk);
      if (capture_rst_n === 1'b1 && dac_request === 1'b1) begin
        dac_buffer  = vecs[vidx];
        up_f.words  = exp_words[vidx];
        up_f.nbits  = (nbits_override.size() > 0) ? nbits_override.pop_front() : BITS;
        exp_frames.push_back(up_f);
        vidx = (vidx + 1) % 3;
      end
    end
  end

  // Monitor: recovers frames on sclk rising edges, checks LDAC and request timing.
  frame_t      fe;
  logic [23:0] cap [4];
  logic        prev_sclk = 1'b1, prev_sync = 1'b1, prev_ldac = 1'b1, prev_req = 1'b0;
  logic        last_complete = 1'b0;
  int          nb = 0, sync_len = 0, end_cyc = 0, ldac_w = 0, last_req = 0;
  int          ldac_pulses = 0, complete_frames = 0, idle_viol = 0, seen_seq = 0;
  initial begin
    for (int c = 0; c < 4; c++) cap[c] = '0;
    forever begin
      @(negedge capture_clk);
      if (dac_sync_n === 1'b0) begin
        sync_len++;
        if (prev_sclk === 1'b0 && dac_sclk === 1'b1) begin
          for (int c = 0; c < 4; c++) cap[c] = {cap[c][22:0], dac_sdo[c]};
          nb++;
        end
      end else begin
        if (dac_sclk !== 1'b1 || dac_sdo !== 4'h0) idle_viol++;
        if (prev_sync === 1'b0) begin
          end_cyc = cyc;
          if (exp_frames.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL frame_unexpected: got frame of %0d bits expected none", nb);
          end else begin
            fe = exp_frames.pop_front();
            chk("frame_bits", nb, fe.nbits);
            if (fe.nbits == BITS) begin
              chk("ch0_data", cap[0], fe.words[95:72]);
              chk("ch1_data", cap[1], fe.words[71:48]);
              chk("ch2_data", cap[2], fe.words[47:24]);
              chk("ch3_data", cap[3], fe.words[23:0]);
              chk("sync_low_len", sync_len, 2 * HALF * BITS);
              complete_frames++;
            end
          end
          last_complete = (nb == BITS);
          nb = 0;
          sync_len = 0;
          for (int c = 0; c < 4; c++) cap[c] = '0;
        end
      end
      if (prev_ldac === 1'b1 && dac_ldac_n === 1'b0) begin
        chk("ldac_delay", cyc - end_cyc, 1);
        chk("ldac_after_full_frame", last_complete, 1);
        last_complete = 1'b0;
        ldac_w = 0;
      end
      if (dac_ldac_n === 1'b0) ldac_w++;
      if (prev_ldac === 1'b0 && dac_ldac_n === 1'b1) begin
        chk("ldac_width", ldac_w, 2);
        ldac_pulses++;
      end
      if (dac_request === 1'b1) begin
        chk("req_prev_low", prev_req, 0);
        if (seen_seq != open_seq) begin
          seen_seq = open_seq;
          if (exp_req.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL req_unexpected: got request at %0d expected none", cyc);
          end else begin
            chk("req_first", cyc, exp_req.pop_front());
          end
        end else begin
          chk("req_spacing", cyc - last_req, DIV);
        end
        last_req = cyc;
      end
      prev_sclk = dac_sclk;
      prev_sync = dac_sync_n;
      prev_ldac = dac_ldac_n;
      prev_req  = dac_request;
    end
  end

  task automatic open_now();
    @(negedge capture_clk);
    dac_open = 1'b1;
    exp_req.push_back(cyc + DIV);
    open_seq++;
  endtask

  task automatic wait_sync_low(string name);
    int n = 0;
    while (dac_sync_n !== 1'b0 && n < 300) begin
      @(negedge capture_clk);
      n++;
    end
    if (n >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: got no sync_n low within 300 cycles expected frame start", name);
    end
  endtask

  task automatic wait_ldac_rise(string name);
    int n = 0;
    while (dac_ldac_n !== 1'b0 && n < 400) begin
      @(negedge capture_clk);
      n++;
    end
    while (dac_ldac_n !== 1'b1 && n < 410) begin
      @(negedge capture_clk);
      n++;
    end
    if (n >= 400) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: got no ldac pulse within 400 cycles expected one", name);
    end
  endtask

  task automatic chk_idle_outputs(string tag);
    chk({tag, "_request"}, dac_request, 0);
    chk({tag, "_sclk"}, dac_sclk, 1);
    chk({tag, "_sync_n"}, dac_sync_n, 1);
    chk({tag, "_sdo"}, dac_sdo, 0);
    chk({tag, "_ldac_n"}, dac_ldac_n, 1);
  endtask

  int saved_pulses;
  initial begin
    capture_rst_n = 1'b0;
    dac_open      = 1'b0;
    dac_underrun  = 1'b0;
    repeat (3) @(negedge capture_clk);
    chk_idle_outputs("reset");
    chk("reset_underrun_count", underrun_count, 0);

    @(negedge capture_clk);
    capture_rst_n = 1'b1;
    repeat (4) @(negedge capture_clk);
    chk_idle_outputs("closed");

    // Request pacing, frame data and LDAC over three frames.
    open_now();
    repeat (3) wait_ldac_rise("frame_ldac");

    // Underrun counting and saturation.
    for (int i = 0; i < 3; i++) begin
      @(negedge capture_clk); dac_underrun = 1'b1;
      @(negedge capture_clk); dac_underrun = 1'b0;
    end
    chk("uc_three", underrun_count, 3);
    dac_underrun = 1'b1;
    repeat (65531) @(negedge capture_clk);
    chk("uc_below_max", underrun_count, 16'hFFFE);
    @(negedge capture_clk);
    chk("uc_at_max", underrun_count, 16'hFFFF);
    repeat (70000 - 65532) @(negedge capture_clk);
    dac_underrun = 1'b0;
    chk("uc_saturated", underrun_count, 16'hFFFF);
    wait_ldac_rise("flood_ldac");
    @(negedge capture_clk);
    dac_open = 1'b0;
    @(negedge capture_clk);
    chk("uc_cleared", underrun_count, 0);
    repeat (3) @(negedge capture_clk);

    // Abort at bit 10, then reopen.
    nbits_override.push_back(10);
    open_now();
    wait_sync_low("abort_sync");
    repeat (20) @(negedge capture_clk);
    saved_pulses = ldac_pulses;
    dac_open = 1'b0;
    @(negedge capture_clk);
    chk_idle_outputs("abort");
    repeat (10) @(negedge capture_clk);
    chk("abort_no_ldac", ldac_pulses, saved_pulses);
    open_now();
    wait_ldac_rise("reopen_ldac");

    // Asynchronous reset in the middle of a frame.
    nbits_override.push_back(4);
    wait_sync_low("rst_sync");
    repeat (7) @(negedge capture_clk);
    #1 capture_rst_n = 1'b0;
    #1 chk_idle_outputs("async_rst");
    chk("async_rst_underrun_count", underrun_count, 0);
    dac_open = 1'b0;
    repeat (3) @(negedge capture_clk);
    capture_rst_n = 1'b1;
    repeat (3) @(negedge capture_clk);

    chk("frames_left", exp_frames.size(), 0);
    chk("requests_left", exp_req.size(), 0);
    chk("idle_sclk_activity", idle_viol, 0);
    chk("ldac_per_full_frame", ldac_pulses, complete_frames);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
